// File: rtl/conv2d_3x3_cfg.sv
// Streaming 3x3 "valid" convolution with line buffers, 3-stage MAC/round/saturate pipeline.
// Optional fused ReLU on the result when CONV_RELU_EN is defined.
module conv2d_3x3_cfg #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned FRAC_BITS  = 8,
    parameter int unsigned IMG_WIDTH  = 30,
    parameter int unsigned IMG_HEIGHT = 30,
    parameter int unsigned STRIDE     = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic signed [DATA_WIDTH-1:0] Data_In,
    input  logic                         Valid_In,
    input  logic signed [DATA_WIDTH-1:0] Kernel0,
    input  logic signed [DATA_WIDTH-1:0] Kernel1,
    input  logic signed [DATA_WIDTH-1:0] Kernel2,
    input  logic signed [DATA_WIDTH-1:0] Kernel3,
    input  logic signed [DATA_WIDTH-1:0] Kernel4,
    input  logic signed [DATA_WIDTH-1:0] Kernel5,
    input  logic signed [DATA_WIDTH-1:0] Kernel6,
    input  logic signed [DATA_WIDTH-1:0] Kernel7,
    input  logic signed [DATA_WIDTH-1:0] Kernel8,
    input  logic signed [DATA_WIDTH-1:0] Bias,
    output logic signed [DATA_WIDTH-1:0] Data_Out,
    output logic                         Valid_Out,
    output logic                         Frame_Done
);

    localparam int unsigned DW     = DATA_WIDTH;
    localparam int unsigned PROD_W = 2 * DW;
    localparam int unsigned SUM_W  = 2 * DW + 4;
    localparam int unsigned COL_W  = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int unsigned ROW_W  = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam int unsigned OUT_W  = (IMG_WIDTH - 3) / STRIDE + 1;
    localparam int unsigned OUT_H  = (IMG_HEIGHT - 3) / STRIDE + 1;
    localparam int unsigned OCW    = (OUT_W > 1) ? $clog2(OUT_W) : 1;
    localparam int unsigned ORW    = (OUT_H > 1) ? $clog2(OUT_H) : 1;

    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [OCW-1:0]   out_col_q, out_col_d;
    logic [ORW-1:0]   out_row_q, out_row_d;
    logic             emit, last, stride_ok;
    logic             v0_q, l0_q, v1_q, l1_q, v2_q, l2_q;

    logic signed [DW-1:0]     lb0_q [IMG_WIDTH];
    logic signed [DW-1:0]     lb1_q [IMG_WIDTH];
    logic signed [DW-1:0]     win_q [9];
    logic signed [DW-1:0]     kern  [9];
    logic signed [PROD_W-1:0] prod_q [9];
    logic signed [SUM_W-1:0]  sum_c, sum_q, rnd_c, shf_c;
    logic        [SUM_W-DW:0] hi_c;
    logic signed [DW-1:0]     res_c;

    assign kern[0] = Kernel0;
    assign kern[1] = Kernel1;
    assign kern[2] = Kernel2;
    assign kern[3] = Kernel3;
    assign kern[4] = Kernel4;
    assign kern[5] = Kernel5;
    assign kern[6] = Kernel6;
    assign kern[7] = Kernel7;
    assign kern[8] = Kernel8;

    // Window emission: (row-2) and (col-2) share parity with row and col for STRIDE 2.
    assign stride_ok = (STRIDE == 1) || (!row_q[0] && !col_q[0]);
    assign emit      = Valid_In && (row_q >= ROW_W'(2)) && (col_q >= COL_W'(2)) && stride_ok;
    assign last      = (out_row_q == ORW'(OUT_H - 1)) && (out_col_q == OCW'(OUT_W - 1));

    always_comb begin
        col_d     = col_q;
        row_d     = row_q;
        out_col_d = out_col_q;
        out_row_d = out_row_q;
        if (Valid_In) begin
            if (col_q == COL_W'(IMG_WIDTH - 1)) begin
                col_d = '0;
                row_d = (row_q == ROW_W'(IMG_HEIGHT - 1)) ? '0 : row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end
        if (emit) begin
            if (out_col_q == OCW'(OUT_W - 1)) begin
                out_col_d = '0;
                out_row_d = last ? '0 : out_row_q + ORW'(1);
            end else begin
                out_col_d = out_col_q + OCW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_q     <= '0;
            row_q     <= '0;
            out_col_q <= '0;
            out_row_q <= '0;
            v0_q      <= 1'b0;
            l0_q      <= 1'b0;
            v1_q      <= 1'b0;
            l1_q      <= 1'b0;
            v2_q      <= 1'b0;
            l2_q      <= 1'b0;
        end else begin
            col_q     <= col_d;
            row_q     <= row_d;
            out_col_q <= out_col_d;
            out_row_q <= out_row_d;
            v0_q      <= emit;
            l0_q      <= emit && last;
            v1_q      <= v0_q;
            l1_q      <= l0_q;
            v2_q      <= v1_q;
            l2_q      <= l1_q;
        end
    end

    // Line buffers and window: contents are don't-care until row 2, so no reset.
    always_ff @(posedge clk) begin
        if (Valid_In) begin
            for (int r = 0; r < 3; r++) begin
                win_q[r*3]   <= win_q[r*3+1];
                win_q[r*3+1] <= win_q[r*3+2];
            end
            win_q[2]     <= lb1_q[col_q];
            win_q[5]     <= lb0_q[col_q];
            win_q[8]     <= Data_In;
            lb1_q[col_q] <= lb0_q[col_q];
            lb0_q[col_q] <= Data_In;
        end
    end

    // S1 products and S2 accumulate run free; the valid tags qualify them.
    always_comb begin
        sum_c = SUM_W'(Bias) <<< FRAC_BITS;
        for (int i = 0; i < 9; i++) begin
            sum_c = sum_c + SUM_W'(prod_q[i]);
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 9; i++) begin
            prod_q[i] <= PROD_W'(win_q[i]) * PROD_W'(kern[i]);
        end
        sum_q <= sum_c;
    end

    // S3: round half up, rescale, saturate to DW bits.
    always_comb begin
        rnd_c = sum_q + (SUM_W'(1) << (FRAC_BITS - 1));
        shf_c = rnd_c >>> FRAC_BITS;
        hi_c  = shf_c[SUM_W-1:DW-1];
        if ((&hi_c) || !(|hi_c)) begin
            res_c = shf_c[DW-1:0];
        end else if (shf_c[SUM_W-1]) begin
            res_c = {1'b1, {(DW-1){1'b0}}};
        end else begin
            res_c = {1'b0, {(DW-1){1'b1}}};
        end
`ifdef CONV_RELU_EN
        if (res_c[DW-1]) begin
            res_c = '0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            Data_Out   <= '0;
            Valid_Out  <= 1'b0;
            Frame_Done <= 1'b0;
        end else begin
            Valid_Out  <= v2_q;
            Frame_Done <= v2_q && l2_q;
            if (v2_q) begin
                Data_Out <= res_c;
            end
        end
    end

endmodule

// File: tb/tb_conv2d_3x3_cfg.sv
// Directed bench for conv2d_3x3_cfg: 5x5 frames into a STRIDE 1 and a STRIDE 2 instance in parallel.
module tb_conv2d_3x3_cfg;

    localparam int unsigned DW = 16;

    typedef struct {
        int val;
        int cyc;
        bit done;
    } exp_t;

    logic                 clk;
    logic                 rst;
    logic signed [DW-1:0] data_in;
    logic                 valid_in;
    logic signed [DW-1:0] kern [9];
    logic signed [DW-1:0] bias;
    logic signed [DW-1:0] do1, do2;
    logic                 vo1, vo2, fd1, fd2;

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   done1 = 0;
    int   done2 = 0;
    int   img_mode = 0;
    int   cval = 0;
    int   exp1 [9];
    int   exp2 [4];
    exp_t q1 [$];
    exp_t q2 [$];

    conv2d_3x3_cfg #(.DATA_WIDTH(16), .FRAC_BITS(8), .IMG_WIDTH(5), .IMG_HEIGHT(5), .STRIDE(1)) dut_s1 (
        .clk(clk), .rst(rst), .Data_In(data_in), .Valid_In(valid_in),
        .Kernel0(kern[0]), .Kernel1(kern[1]), .Kernel2(kern[2]), .Kernel3(kern[3]), .Kernel4(kern[4]),
        .Kernel5(kern[5]), .Kernel6(kern[6]), .Kernel7(kern[7]), .Kernel8(kern[8]), .Bias(bias),
        .Data_Out(do1), .Valid_Out(vo1), .Frame_Done(fd1)
    );

    conv2d_3x3_cfg #(.DATA_WIDTH(16), .FRAC_BITS(8), .IMG_WIDTH(5), .IMG_HEIGHT(5), .STRIDE(2)) dut_s2 (
        .clk(clk), .rst(rst), .Data_In(data_in), .Valid_In(valid_in),
        .Kernel0(kern[0]), .Kernel1(kern[1]), .Kernel2(kern[2]), .Kernel3(kern[3]), .Kernel4(kern[4]),
        .Kernel5(kern[5]), .Kernel6(kern[6]), .Kernel7(kern[7]), .Kernel8(kern[8]), .Bias(bias),
        .Data_Out(do2), .Valid_Out(vo2), .Frame_Done(fd2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Output monitor: pops the scoreboard in order and checks value, latency and Frame_Done.
    always @(negedge clk) begin
        exp_t e;
        if (vo1) begin
            if (fd1) done1++;
            if (q1.size() == 0) check("s1_unexpected_out", 1, 0);
            else begin
                e = q1.pop_front();
                check("s1_data", int'(do1), e.val);
                check("s1_latency", cyc, e.cyc);
                check("s1_frame_done", int'(fd1), int'(e.done));
            end
        end else if (fd1) check("s1_stray_done", 1, 0);
        if (vo2) begin
            if (fd2) done2++;
            if (q2.size() == 0) check("s2_unexpected_out", 1, 0);
            else begin
                e = q2.pop_front();
                check("s2_data", int'(do2), e.val);
                check("s2_latency", cyc, e.cyc);
                check("s2_frame_done", int'(fd2), int'(e.done));
            end
        end else if (fd2) check("s2_stray_done", 1, 0);
    end

    function automatic logic signed [DW-1:0] pix(input int r, input int c);
        if (img_mode == 0) return DW'(256 * (r * 5 + c));
        return DW'(cval);
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            valid_in = 1'b0;
        end
    endtask

    // Drives npix pixels of a 5x5 frame; the sampling edge is the next posedge, output seen 3 edges later.
    task automatic drive_frame(input bit bubbles, input int npix);
        int   k1 = 0;
        int   k2 = 0;
        exp_t e;
        for (int p = 0; p < npix; p++) begin
            int r = p / 5;
            int c = p % 5;
            if (bubbles) idle($urandom_range(2, 0));
            @(negedge clk);
            data_in  = pix(r, c);
            valid_in = 1'b1;
            if (r >= 2 && c >= 2) begin
                e.val = exp1[k1]; e.cyc = cyc + 4; e.done = (k1 == 8);
                q1.push_back(e);
                k1++;
                if (r % 2 == 0 && c % 2 == 0) begin
                    e.val = exp2[k2]; e.cyc = cyc + 4; e.done = (k2 == 3);
                    q2.push_back(e);
                    k2++;
                end
            end
        end
    endtask

    task automatic set_const_exp(input int v);
        for (int i = 0; i < 9; i++) exp1[i] = v;
        for (int i = 0; i < 4; i++) exp2[i] = v;
    endtask

    task automatic clear_kern();
        for (int i = 0; i < 9; i++) kern[i] = '0;
    endtask

    initial begin
        int s1, s2;
        rst      = 1'b0;
        valid_in = 1'b0;
        data_in  = '0;
        bias     = '0;
        clear_kern();
        repeat (3) @(negedge clk);
        check("rst_valid_out_s1", int'(vo1), 0);
        check("rst_data_out_s1", int'(do1), 0);
        check("rst_frame_done_s1", int'(fd1), 0);
        check("rst_valid_out_s2", int'(vo2), 0);
        check("rst_data_out_s2", int'(do2), 0);
        check("rst_frame_done_s2", int'(fd2), 0);
        rst = 1'b1;

        // Ramp image through identity kernel: outputs are the window centres.
        img_mode = 0;
        kern[4]  = 16'sd256;
        exp1 = '{1536, 1792, 2048, 2816, 3072, 3328, 4096, 4352, 4608};
        exp2 = '{1536, 2048, 4096, 4608};
        drive_frame(1'b0, 25);
        idle(8);
        check("hold_data_s1", int'(do1), 4608);
        check("hold_data_s2", int'(do2), 4608);
        check("hold_valid_s1", int'(vo1), 0);

        // Same frame with random input bubbles.
        drive_frame(1'b1, 25);
        idle(8);

        // Positive saturation.
        img_mode = 1;
        cval     = 32767;
        for (int i = 0; i < 9; i++) kern[i] = 16'sd32767;
        set_const_exp(32767);
        drive_frame(1'b0, 25);
        idle(8);

        // Negative saturation, clamped when ReLU is fused.
        clear_kern();
        kern[0] = -16'sd32768;
`ifdef CONV_RELU_EN
        set_const_exp(0);
`else
        set_const_exp(-32768);
`endif
        drive_frame(1'b0, 25);
        idle(8);

        // Half-LSB rounding, then bias alone.
        cval = 1;
        clear_kern();
        kern[4] = 16'sd128;
        set_const_exp(1);
        drive_frame(1'b0, 25);
        idle(8);
        clear_kern();
        bias = 16'sd256;
        set_const_exp(256);
        drive_frame(1'b0, 25);
        idle(8);

        // Two back-to-back frames, partial third frame killed by reset, then a fresh frame.
        bias     = '0;
        img_mode = 0;
        kern[4]  = 16'sd256;
        exp1 = '{1536, 1792, 2048, 2816, 3072, 3328, 4096, 4352, 4608};
        exp2 = '{1536, 2048, 4096, 4608};
        s1 = done1;
        s2 = done2;
        drive_frame(1'b0, 25);
        drive_frame(1'b0, 25);
        drive_frame(1'b0, 12);
        @(negedge clk);
        valid_in = 1'b0;
        rst      = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("in_rst_valid_s1", int'(vo1), 0);
            check("in_rst_valid_s2", int'(vo2), 0);
        end
        rst = 1'b1;
        idle(4);
        check("b2b_done_count_s1", done1 - s1, 2);
        check("b2b_done_count_s2", done2 - s2, 2);
        drive_frame(1'b0, 25);
        idle(10);
        check("final_done_count_s1", done1 - s1, 3);
        check("q1_drained", q1.size(), 0);
        check("q2_drained", q2.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/conv2d_3x3_cfg.md
# conv2d_3x3_cfg

Parametrised streaming 3x3 convolution engine: the next generation of the fixed 32-bit, stride-2 convolution block. It accepts a raster-order pixel stream, builds the 3x3 window internally with two line buffers, and computes a "valid" (unpadded) convolution in signed fixed point. Stride, data width, fractional bits and image size are generic, and an optional fused ReLU is available. It sits between the pixel source (or a previous layer) and the pooling/activation stages of the CNN datapath.

## Interface
Parameters:
- DATA_WIDTH, 16: signed pixel/kernel/bias/result width.
- FRAC_BITS, 8: fractional bits of every operand (Q(DATA_WIDTH-FRAC_BITS).FRAC_BITS); range 1..DATA_WIDTH-2.
- IMG_WIDTH, 30: input columns, >= 3.
- IMG_HEIGHT, 30: input rows, >= 3.
- STRIDE, 1: window step, horizontal and vertical; legal values are 1 and 2.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- Data_In  in  DATA_WIDTH  pixel, raster order (row-major, left to right).
- Valid_In  in  1  Data_In qualifier; bubbles allowed; no backpressure.
- Kernel0..Kernel8  in  DATA_WIDTH each  weights, row-major (Kernel0 = top-left); must be stable for the whole frame.
- Bias  in  DATA_WIDTH  added to every output; same Q format.
- Data_Out  out  DATA_WIDTH  result.
- Valid_Out  out  1  one-cycle strobe per output pixel.
- Frame_Done  out  1  strobe coincident with the last output pixel of a frame.

## Operation
- Input counters col (0..IMG_WIDTH-1) and row (0..IMG_HEIGHT-1) advance only on Valid_In. col wraps to 0 and row increments; after the last pixel both wrap to 0 and the next frame begins with no gap required.
- Two line buffers of IMG_WIDTH entries plus a 3x3 shift window. The window is updated only on Valid_In.
- A window is emitted when row >= 2, col >= 2, (row-2) mod STRIDE == 0 and (col-2) mod STRIDE == 0.
- Output size: OUT_W = (IMG_WIDTH-3)/STRIDE + 1 and OUT_H = (IMG_HEIGHT-3)/STRIDE + 1, using integer division. Trailing columns and rows that do not fit a full step are discarded.
- Pipeline, free-running with a valid tag per stage:
  - S1: 9 signed products of 2*DATA_WIDTH bits.
  - S2: sum of the products plus Bias << FRAC_BITS, 2*DATA_WIDTH+4 bits, no overflow possible.
  - S3: add 1 << (FRAC_BITS-1), arithmetic shift right by FRAC_BITS (round half up), then saturate to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
- Output counters (out_col, out_row) advance on each emitted window. Frame_Done asserts with the output at (OUT_H-1, OUT_W-1), then both counters clear.
- Data_Out is registered and holds its last value while Valid_Out is low.

## Timing
- Reset values: Data_Out = 0, Valid_Out = 0, Frame_Done = 0, all counters = 0, pipeline valid tags = 0. Line-buffer contents are don't-care, because no window is emitted before row 2.
- Latency: a Valid_In pixel that completes an emitting window at edge t produces Valid_Out and Data_Out at edge t+3. The latency is fixed and independent of bubbles.
- Throughput: one output per cycle maximum (STRIDE=1 with a continuous stream).
- Back-to-back frames: the last output of frame N and the first windows of frame N+1 may occupy the pipeline simultaneously. Results stay ordered and Frame_Done marks only frame N's final output.
- Reset asserted mid-frame: all in-flight results are dropped and no Valid_Out is produced during reset. The pixel after release is treated as (0,0).
- Valid_In low: nothing shifts and nothing is emitted; pipeline stages already holding data still drain.

## Configuration
- CONV_RELU_EN defined: S3 clamps negative saturated results to 0 in the same cycle. Latency is unchanged.
- CONV_RELU_EN undefined: signed results pass through unmodified.

## Test plan
All scenarios use DATA_WIDTH=16, FRAC_BITS=8.
- 5x5 ramp (pixel = 256*(r*5+c)), identity kernel (Kernel4=256, others 0), Bias 0, STRIDE 1 -> 9 outputs equal to the centre pixels 1536, 1792, 2048, 2816, ..., 4608; Frame_Done on the 9th output; each output arrives 3 cycles after its completing input.
- Same image and kernel, STRIDE 2 -> 4 outputs: 1536, 2048, 4096, 4608.
- All pixels 32767, all kernels 32767, Bias 0 -> every output is 32767 (positive saturation). With Kernel0 = -32768 and the others 0 -> -32768 without CONV_RELU_EN and 0 with it.
- Random Valid_In bubbles (~50% duty) on the 5x5 case -> same outputs and order as the continuous run; the completing-input-to-output gap is always 3 cycles.
- Two back-to-back 5x5 frames, then reset pulsed after 12 pixels of a third frame -> exactly 18 outputs with 2 Frame_Done pulses, and no output for the partial frame. After release, a fresh frame yields the correct 9 outputs.
- Half-LSB rounding: pixels 1 with Kernel4=128 (product 128, half an LSB) -> output 1. Bias 256 with an all-zero kernel -> output 256.
